// File: rtl/ice_sl_arbiter_pkg.sv
// Shared definitions for the slave-bus arbiter: FSM state encoding and width helpers.
package ice_sl_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    // A single requester still needs a one-bit id field.
    function automatic int grant_id_width(input int num_dev);
        return (num_dev > 1) ? $clog2(num_dev) : 1;
    endfunction

    function automatic int hold_cnt_width(input int hold_timeout);
        return $clog2(hold_timeout) + 1;
    endfunction

endpackage

// File: rtl/ice_sl_arbiter_rr_pick.sv
// Combinational round-robin pick: first eligible index at or after rr_ptr, wrapping.
module ice_sl_arbiter_rr_pick
    import ice_sl_arbiter_pkg::*;
#(
    parameter int NUM_DEV = 7,
    parameter int ID_W    = grant_id_width(NUM_DEV)
) (
    input  logic [NUM_DEV-1:0] eligible,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_DEV-1:0] pick_onehot,
    output logic [ID_W-1:0]    pick_id,
    output logic               pick_valid
);

    logic [NUM_DEV-1:0] upper;
    logic [NUM_DEV-1:0] search;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DEV; gi++) begin : g_upper
            assign upper[gi] = eligible[gi] & (ID_W'(gi) >= rr_ptr);
        end
    endgenerate

    // Nothing at or above the pointer means the search wraps to index 0.
    assign search     = (|upper) ? upper : eligible;
    assign pick_valid = |eligible;

    always_comb begin
        pick_onehot = '0;
        pick_id     = '0;
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if (search[i]) begin
                pick_onehot    = '0;
                pick_onehot[i] = 1'b1;
                pick_id        = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/ice_sl_arbiter.sv
// Slave-bus arbiter: round-robin grants with hold timeout, per-requester lockout and inter-grant gap.
module ice_sl_arbiter
    import ice_sl_arbiter_pkg::*;
#(
    parameter int NUM_DEV      = 7,
    parameter int HOLD_TIMEOUT = 4096,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               arb_enable,
    input  logic [NUM_DEV-1:0]                 sl_arb_request,
    output logic [NUM_DEV-1:0]                 sl_arb_grant,
    output logic                               grant_valid,
    output logic [grant_id_width(NUM_DEV)-1:0] grant_id,
    output logic                               timeout_evt,
    output logic [NUM_DEV-1:0]                 lockout
);

    localparam int ID_W    = grant_id_width(NUM_DEV);
    localparam int HC_W    = hold_cnt_width(HOLD_TIMEOUT);
    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int GC_W    = $clog2(GAP_EFF + 1);

    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_TIMEOUT - 1);
    localparam logic [HC_W-1:0] HOLD_MAX  = '1;
    localparam logic [GC_W-1:0] GAP_LAST  = GC_W'(GAP_EFF - 1);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_DEV - 1);

    arb_state_t         state_reg;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [HC_W-1:0]    hold_cnt_reg;
    logic [GC_W-1:0]    gap_cnt_reg;

    logic [NUM_DEV-1:0] eligible;
    logic [NUM_DEV-1:0] pick_onehot;
    logic [ID_W-1:0]    pick_id;
    logic               pick_valid;
    logic               owner_req;
    logic [ID_W-1:0]    next_ptr;

    assign eligible  = sl_arb_request & ~lockout;
    assign owner_req = |(sl_arb_request & sl_arb_grant);
    assign next_ptr  = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

    ice_sl_arbiter_rr_pick #(
        .NUM_DEV (NUM_DEV),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr_reg),
        .pick_onehot (pick_onehot),
        .pick_id     (pick_id),
        .pick_valid  (pick_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= '0;
            hold_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            sl_arb_grant <= '0;
            grant_valid  <= 1'b0;
            grant_id     <= '0;
            timeout_evt  <= 1'b0;
            lockout      <= '0;
        end else begin
            timeout_evt <= 1'b0;
            // A barred requester is released once it has dropped its request.
            lockout     <= lockout & sl_arb_request;

            case (state_reg)
                ST_IDLE: begin
                    if (arb_enable && pick_valid) begin
                        sl_arb_grant <= pick_onehot;
                        grant_valid  <= 1'b1;
                        grant_id     <= pick_id;
                        hold_cnt_reg <= '0;
                        state_reg    <= ST_GRANT;
                    end
                end

                ST_GRANT: begin
                    if (!owner_req || hold_cnt_reg == HOLD_LAST) begin
                        sl_arb_grant <= '0;
                        grant_valid  <= 1'b0;
                        grant_id     <= '0;
                        rr_ptr_reg   <= next_ptr;
                        gap_cnt_reg  <= '0;
                        state_reg    <= ST_GAP;
                        // A drop coinciding with the timeout is an ordinary release.
                        if (owner_req) begin
                            timeout_evt <= 1'b1;
                            lockout     <= (lockout & sl_arb_request) | sl_arb_grant;
                        end
                    end else if (hold_cnt_reg != HOLD_MAX) begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ice_sl_arbiter.sv
// Directed bench for ice_sl_arbiter with a cycle-level behavioural reference model.
module tb_ice_sl_arbiter;

    localparam int N   = 7;
    localparam int HT  = 16;
    localparam int GAP = 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         arb_enable = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [2:0]   grant_id;
    logic         timeout_evt;
    logic [N-1:0] lockout;

    int errors = 0;
    int checks = 0;

    // Reference model state: current owner (-1 = none), cycles held so far, gap cycles left.
    int           m_owner = -1;
    int           m_held  = 0;
    int           m_gap   = 0;
    int           m_ptr   = 0;
    int           m_c;
    logic [N-1:0] m_lock = '0;
    logic [N-1:0] m_old_lock;
    logic [N-1:0] m_elig;
    logic         m_tevt = 1'b0;
    logic         m_found;

    always #5 clk = ~clk;

    ice_sl_arbiter #(
        .NUM_DEV      (N),
        .HOLD_TIMEOUT (HT),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .arb_enable     (arb_enable),
        .sl_arb_request (req),
        .sl_arb_grant   (grant),
        .grant_valid    (grant_valid),
        .grant_id       (grant_id),
        .timeout_evt    (timeout_evt),
        .lockout        (lockout)
    );

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner = -1;
            m_held  = 0;
            m_gap   = 0;
            m_ptr   = 0;
            m_lock  = '0;
            m_tevt  = 1'b0;
        end else begin
            m_tevt     = 1'b0;
            m_old_lock = m_lock;
            m_lock     = m_lock & req;
            if (m_owner >= 0) begin
                if (!req[m_owner]) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_gap   = GAP;
                end else if (m_held == HT) begin
                    m_lock[m_owner] = 1'b1;
                    m_tevt  = 1'b1;
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_gap   = GAP;
                end else begin
                    m_held = m_held + 1;
                end
            end else if (m_gap > 0) begin
                m_gap = m_gap - 1;
            end else if (arb_enable) begin
                m_elig  = req & ~m_old_lock;
                m_found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    m_c = (m_ptr + k) % N;
                    if (!m_found && m_elig[m_c]) begin
                        m_found = 1'b1;
                        m_owner = m_c;
                        m_held  = 1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare against the model mid-cycle, then advance to just after the next rising edge.
    task automatic step();
        logic [N-1:0] eg;
        logic [2:0]   eid;
        @(negedge clk);
        eg  = '0;
        eid = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            eid = 3'(m_owner);
        end
        check("model_cycle {grant,valid,id,tevt,lockout}",
              {13'd0, grant, grant_valid, grant_id, timeout_evt, lockout},
              {13'd0, eg, (m_owner >= 0), eid, m_tevt, m_lock});
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        req        = '0;
        arb_enable = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic wait_grant(input int budget, output int waited);
        waited = 0;
        while (!grant_valid && waited < budget) begin
            step();
            waited++;
        end
        check("wait_grant", grant_valid, 1'b1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        int n;
        int exp_ids[4];
        exp_ids = '{0, 6, 0, 6};

        // Reset state
        #1 reset = 1'b0;
        #2;
        check("rst_grant", grant, 0);
        check("rst_valid", grant_valid, 0);
        check("rst_id", grant_id, 0);
        check("rst_tevt", timeout_evt, 0);
        check("rst_lockout", lockout, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        step();

        // Single requester, release, gap, regrant
        req = 7'b0000100;
        arb_enable = 1'b1;
        step();
        check("r031_grant", grant, 7'b0000100);
        check("r031_id", grant_id, 2);
        step();
        step();
        req = '0;
        step();
        check("r031_release", grant_valid, 0);
        req = 7'b0001000;
        step();
        check("r031_gap", grant, 0);
        step();
        check("r031_regrant", grant, 7'b0001000);
        req = '0;
        repeat (3) step();

        // Alternating owners 0 and 6
        do_reset();
        arb_enable = 1'b1;
        req = 7'b1000001;
        for (int r = 0; r < 4; r++) begin
            wait_grant(8, w);
            if (r > 0) check("r032_gap_len", w, GAP + 1);
            check("r032_owner", grant_id, exp_ids[r]);
            repeat (9) step();
            check("r032_hold", grant_valid, 1);
            req[exp_ids[r]] = 1'b0;
            step();
            check("r032_release", grant_valid, 0);
            req[exp_ids[r]] = 1'b1;
        end
        req = '0;
        repeat (3) step();

        // Timeout and lockout
        do_reset();
        arb_enable = 1'b1;
        req = 7'b0001000;
        wait_grant(4, w);
        n = 1;
        while (grant_valid && n < 40) begin
            step();
            if (grant_valid) n++;
        end
        check("r033_hold_len", n, HT);
        check("r033_tevt", timeout_evt, 1);
        check("r033_lockout", lockout, 7'b0001000);
        step();
        check("r033_tevt_pulse", timeout_evt, 0);
        repeat (5) step();
        check("r033_no_regrant", grant_valid, 0);
        check("r033_lock_held", lockout, 7'b0001000);
        req = '0;
        step();
        check("r033_lock_clear", lockout, 0);
        req = 7'b0001000;
        wait_grant(6, w);
        check("r033_regrant_id", grant_id, 3);
        req = '0;
        repeat (3) step();

        // Release in the exact timeout cycle
        do_reset();
        arb_enable = 1'b1;
        req = 7'b0000010;
        wait_grant(4, w);
        repeat (HT - 1) step();
        check("r034_still_granted", grant, 7'b0000010);
        req = '0;
        step();
        check("r034_released", grant_valid, 0);
        check("r034_tevt", timeout_evt, 0);
        check("r034_lockout", lockout, 0);
        repeat (3) step();

        // Enable low holds current grant but blocks new ones; pointer wraps
        do_reset();
        arb_enable = 1'b1;
        req = 7'b0100000;
        wait_grant(4, w);
        check("r035_owner", grant_id, 5);
        arb_enable = 1'b0;
        req = 7'b0100101;
        repeat (3) step();
        check("r035_hold", grant, 7'b0100000);
        req = 7'b0000101;
        step();
        check("r035_release", grant_valid, 0);
        repeat (4) step();
        check("r035_blocked", grant_valid, 0);
        arb_enable = 1'b1;
        step();
        check("r035_wrap_grant", grant, 7'b0000001);
        req = '0;
        repeat (3) step();

        // Asynchronous reset mid-grant
        do_reset();
        arb_enable = 1'b1;
        req = 7'b0010000;
        wait_grant(4, w);
        check("r036_owner", grant_id, 4);
        step();
        step();
        #1 reset = 1'b0;
        #1;
        check("r036_async_grant", grant, 0);
        check("r036_async_valid", grant_valid, 0);
        check("r036_async_id", grant_id, 0);
        check("r036_async_tevt", timeout_evt, 0);
        check("r036_async_lockout", lockout, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        step();
        check("r036_regrant", grant, 7'b0010000);
        check("r036_regrant_id", grant_id, 4);
        req = '0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ice_sl_arbiter.md
ICE_SL_ARBITER -- requirements
Module: ice_sl_arbiter

Interface
REQ-001 Parameter NUM_DEV, default 7, number of slave-bus requesters.
REQ-002 Parameter HOLD_TIMEOUT, default 4096, maximum cycles one owner may hold the grant.
REQ-003 Parameter GAP_CYCLES, default 1, idle cycles (minimum 1) inserted between successive grants.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 arb_enable  input  1  when high, new grants may be issued.
REQ-007 sl_arb_request  input  NUM_DEV  per-requester bus request, held high until its frame tail is sent.
REQ-008 sl_arb_grant  output  NUM_DEV  registered one-hot grant (or all zero).
REQ-009 grant_valid  output  1  high when any grant bit is high.
REQ-010 grant_id  output  clog2(NUM_DEV)  index of current owner; 0 when no grant.
REQ-011 timeout_evt  output  1  one-cycle pulse when a grant is revoked by timeout.
REQ-012 lockout  output  NUM_DEV  requesters currently barred after a timeout.

Function
REQ-013 FSM states IDLE, GRANT, GAP; the FSM SHALL leave reset in IDLE.
REQ-014 IDLE: if arb_enable=1 and eligible = sl_arb_request & ~lockout is nonzero, select the first eligible index at or after rr_ptr (wrapping NUM_DEV-1 to 0), register its grant, and enter GRANT; the grant is visible the cycle after the request is sampled (latency 1).
REQ-015 GRANT: hold_cnt increments every cycle from 0; the grant is held while the owner's request stays high.
REQ-016 Owner request low in GRANT: clear grant next cycle, set rr_ptr = (owner+1) mod NUM_DEV, enter GAP.
REQ-017 hold_cnt = HOLD_TIMEOUT-1 with owner request still high: clear grant next cycle, pulse timeout_evt in that same cycle, set lockout[owner], advance rr_ptr as REQ-016, enter GAP.
REQ-018 Request drop and timeout in the same cycle: treat as a normal release; no timeout_evt and no lockout.
REQ-019 GAP: remain exactly GAP_CYCLES cycles with no grant, then enter IDLE.
REQ-020 lockout[i] clears the cycle after sl_arb_request[i] is sampled low; a locked requester is never granted.
REQ-021 arb_enable falling during GRANT does not revoke the current grant; only new grants are blocked.
REQ-022 Requests from non-owners during GRANT or GAP are ignored until IDLE; no requests are queued.
REQ-023 At most one grant bit is high in any cycle; no grant in IDLE or GAP.
REQ-024 hold_cnt is width clog2(HOLD_TIMEOUT)+1, saturating and never wrapping; it resets to 0 on every grant.

Reset
REQ-025 Reset asserted: sl_arb_grant=0, grant_valid=0, grant_id=0, timeout_evt=0, lockout=0, rr_ptr=0, hold_cnt=0, state=IDLE, applied immediately without waiting for clk.
REQ-026 Reset asserted mid-grant: the grant drops asynchronously; after release the first grant follows REQ-014 from rr_ptr=0.
REQ-027 Reset deassertion: the synchronizer is outside this block; the block itself assumes nothing about deassertion timing.

Structure
REQ-028 The FSM state encoding and the GRANT_ID width function belong in the shared ice bus package; parameter defaults stay in the module.
REQ-029 The round-robin priority pick (eligible vector plus rr_ptr in, one-hot out) is one sub-module, rr_pick, which is purely combinational.
REQ-030 The instantiating module replaces the existing arbitration in ice_bus_controller with this block on the same sl_arb_request/sl_arb_grant vectors.

Verification
REQ-031 Reset, then request=7'b0000100, enable=1 -> grant=7'b0000100 one cycle later, grant_id=2; drop request -> grant 0 next cycle, 1 GAP cycle, then IDLE.
REQ-032 request=7'b1000001 held continuously with rr_ptr=0 -> grants alternate in the order 0, 6, 0, 6, ... with each owner releasing after 10 cycles, and every inter-grant gap is 1 cycle.
REQ-033 HOLD_TIMEOUT=16, requester 3 never drops -> grant revoked after 16 cycles, timeout_evt pulses once, lockout[3]=1, no regrant; dropping request 3 clears lockout next cycle.
REQ-034 Owner 1 drops request in exactly the timeout cycle -> timeout_evt=0 and lockout=0.
REQ-035 Grant to 5 active, enable=0 -> grant held until request 5 drops, then no further grants with requests 0 and 2 pending; enable=1 -> grant to 0 (rr_ptr=6, wraps).
REQ-036 Reset pulsed low mid-grant to 4 -> all outputs 0 asynchronously; after release with request=7'b0010000 -> grant to 4 one cycle later.
